// File: rtl/ex_hazard_pipe.sv
// EX-stage hazard pipeline: holds the ID/EX, EX/MEM and MEM/WB destination/control fields,
// resolves load-use stalls, branch flushes and memory-wait freezes, and counts stall cycles.
module ex_hazard_pipe #(
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ID_valid,
    input  logic [4:0]           i_ID_Rs,
    input  logic [4:0]           i_ID_Rt,
    input  logic [4:0]           i_ID_write_register,
    input  logic                 i_ID_reg_write,
    input  logic                 i_ID_mem_read,
    input  logic                 i_ID_mem_write,
    input  logic                 i_EX_branch_taken,
    input  logic                 i_mem_ready,
    output logic [4:0]           o_ID_EX_Rs,
    output logic [4:0]           o_ID_EX_Rt,
    output logic [4:0]           o_write_register_MEM,
    output logic [4:0]           o_write_register_WB,
    output logic                 o_EX_MEM_reg_write,
    output logic                 o_MEM_WB_reg_write,
    output logic                 o_pc_write,
    output logic                 o_IF_ID_write,
    output logic                 o_IF_ID_flush,
    output logic [CNT_WIDTH-1:0] o_stall_cycles,
    output logic                 o_mem_timeout
);

    localparam int unsigned RW     = 5;
    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef struct packed {
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] wr;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
    } id_ex_t;

    typedef struct packed {
        logic [RW-1:0] wr;
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
    } ex_mem_t;

    typedef struct packed {
        logic [RW-1:0] wr;
        logic          reg_write;
    } mem_wb_t;

    id_ex_t               id_ex;
    id_ex_t               id_ex_next;
    ex_mem_t              ex_mem;
    mem_wb_t              mem_wb;
    logic                 freeze;
    logic                 load_use;
    logic                 branch;
    logic                 lu_stall;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [CNT_WIDTH-1:0] stall_cnt;
    logic                 timeout;

    // Hazard decode; priority is freeze > branch > load-use.
    always_comb begin
        freeze        = (ex_mem.mem_read | ex_mem.mem_write) & ~i_mem_ready;
        load_use      = i_ID_valid & id_ex.mem_read & (id_ex.wr != '0) &
                        ((id_ex.wr == i_ID_Rs) | (id_ex.wr == i_ID_Rt));
        branch        = i_EX_branch_taken & ~freeze;
        lu_stall      = load_use & ~freeze & ~i_EX_branch_taken;
        o_pc_write    = ~i_rst & ~freeze & ~lu_stall;
        o_IF_ID_write = ~i_rst & ~freeze & ~lu_stall;
        o_IF_ID_flush = i_rst | branch;
    end

    // ID/EX load value: bubble on invalid ID, branch flush or load-use stall.
    always_comb begin
        id_ex_next = '0;
        if (i_ID_valid && !branch && !lu_stall) begin
            id_ex_next.rs        = i_ID_Rs;
            id_ex_next.rt        = i_ID_Rt;
            id_ex_next.wr        = i_ID_write_register;
            id_ex_next.reg_write = i_ID_reg_write & (i_ID_write_register != '0);
            id_ex_next.mem_read  = i_ID_mem_read;
            id_ex_next.mem_write = i_ID_mem_write;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            id_ex  <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
        end else if (!freeze) begin
            id_ex            <= id_ex_next;
            ex_mem.wr        <= id_ex.wr;
            ex_mem.reg_write <= id_ex.reg_write;
            ex_mem.mem_read  <= id_ex.mem_read;
            ex_mem.mem_write <= id_ex.mem_write;
            mem_wb.wr        <= ex_mem.wr;
            mem_wb.reg_write <= ex_mem.reg_write;
        end
    end

    // Saturating stall counter and consecutive memory-wait tracking with sticky timeout.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_cnt <= '0;
            wait_cnt  <= '0;
            timeout   <= 1'b0;
        end else begin
            if (!o_pc_write && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
            if (freeze) begin
                if (wait_cnt != WAIT_W'(MEM_TIMEOUT)) begin
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                end
                if (wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1)) begin
                    timeout <= 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    assign o_ID_EX_Rs           = id_ex.rs;
    assign o_ID_EX_Rt           = id_ex.rt;
    assign o_write_register_MEM = ex_mem.wr;
    assign o_write_register_WB  = mem_wb.wr;
    assign o_EX_MEM_reg_write   = ex_mem.reg_write;
    assign o_MEM_WB_reg_write   = mem_wb.reg_write;
    assign o_stall_cycles       = stall_cnt;
    assign o_mem_timeout        = timeout;

endmodule

// File: doc/ex_hazard_pipe.md
Name: ex_hazard_pipe

Overview:
- Producer side of the EX-stage forwarding interface.
- Owns the destination/control fields of the ID/EX, EX/MEM and MEM/WB pipeline registers, and drives the Rs/Rt, write-register and reg-write signals the forwarding unit compares.
- Detects load-use hazards and inserts bubbles, applies branch flushes, and freezes the pipeline while data memory is not ready.
- Keeps a stall-cycle counter and a memory-timeout flag.

Parameters:
- CNT_WIDTH, 16, width of the saturating stall-cycle counter.
- MEM_TIMEOUT, 64, consecutive memory-wait cycles after which o_mem_timeout sets.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  asynchronous reset, active-high.
- i_ID_valid  input  1  ID holds a real instruction.
- i_ID_Rs  input  5  ID source register Rs.
- i_ID_Rt  input  5  ID source register Rt.
- i_ID_write_register  input  5  ID destination register.
- i_ID_reg_write  input  1  ID instruction writes the register file.
- i_ID_mem_read  input  1  ID instruction is a load.
- i_ID_mem_write  input  1  ID instruction is a store.
- i_EX_branch_taken  input  1  branch resolved taken in EX.
- i_mem_ready  input  1  data memory completes the access this cycle.
- o_ID_EX_Rs  output  5  ID/EX Rs.
- o_ID_EX_Rt  output  5  ID/EX Rt.
- o_write_register_MEM  output  5  EX/MEM destination register.
- o_write_register_WB  output  5  MEM/WB destination register.
- o_EX_MEM_reg_write  output  1  EX/MEM reg-write flag.
- o_MEM_WB_reg_write  output  1  MEM/WB reg-write flag.
- o_pc_write  output  1  PC update enable.
- o_IF_ID_write  output  1  IF/ID register enable.
- o_IF_ID_flush  output  1  clear IF/ID.
- o_stall_cycles  output  CNT_WIDTH  saturating count of cycles with o_pc_write=0.
- o_mem_timeout  output  1  sticky memory-timeout flag.

Behaviour:
- Reset (async, i_rst=1): all stage fields cleared (registers 0, flags 0), o_stall_cycles=0, o_mem_timeout=0, wait counter=0. While i_rst=1: o_pc_write=0, o_IF_ID_write=0, o_IF_ID_flush=1.
- Stage contents:
  - ID/EX holds Rs, Rt, wr, reg_write, mem_read, mem_write.
  - EX/MEM holds wr, reg_write, mem_read, mem_write.
  - MEM/WB holds wr, reg_write.
  - Normal advance: ID->ID/EX->EX/MEM->MEM/WB each cycle, 1-cycle latency per stage.
- freeze = EX/MEM (mem_read|mem_write) & !i_mem_ready. While frozen:
  - All three stage registers hold.
  - o_pc_write=0, o_IF_ID_write=0, o_IF_ID_flush=0.
  - Branch and load-use actions are suppressed; EX holds i_EX_branch_taken stable because EX is also frozen.
- load_use = i_ID_valid & ID/EX mem_read & ID/EX wr!=0 & (ID/EX wr==i_ID_Rs | ID/EX wr==i_ID_Rt). When not frozen:
  - o_pc_write=0, o_IF_ID_write=0.
  - Bubble loaded into ID/EX: all fields 0.
  - EX/MEM and MEM/WB advance.
- Branch (not frozen, i_EX_branch_taken=1):
  - o_IF_ID_flush=1.
  - Bubble loaded into ID/EX.
  - o_pc_write=1.
  - Takes priority over load_use.
- Priority: reset > freeze > branch > load_use > normal.
- Invalid ID (i_ID_valid=0) loads a bubble into ID/EX.
- Register 0 destination:
  - Forced reg_write=0 when entering ID/EX.
  - Never triggers load-use.
- o_stall_cycles: +1 on every clock edge where o_pc_write was 0 after reset is released; saturates at 2^CNT_WIDTH-1.
- Wait counter:
  - Increments on each frozen cycle; clears on any non-frozen cycle.
  - When it reaches MEM_TIMEOUT, o_mem_timeout sets. The flag is sticky until reset; the freeze continues regardless.
- Reset asserted mid-freeze or mid-stall: immediate clear of all fields; pipeline restarts empty.

Test Plan:
1. Reset, then ADD $3 followed by SUB using $3 -> o_write_register_MEM=3 and o_EX_MEM_reg_write=1 one cycle after ID/EX; the following cycle o_write_register_WB=3 and o_MEM_WB_reg_write=1; o_pc_write stays 1.
2. LW $5 in ID/EX, ID reads Rt=5 -> one cycle with o_pc_write=0 and o_IF_ID_write=0; ID/EX becomes a bubble (wr=0, reg_write=0); o_stall_cycles=1.
3. LW in EX/MEM with i_mem_ready=0 for 3 cycles -> all stage outputs constant for 3 cycles, o_pc_write=0 throughout, o_stall_cycles=3; advance on the cycle i_mem_ready=1.
4. i_EX_branch_taken=1 together with a load-use condition -> o_IF_ID_flush=1, o_pc_write=1, ID/EX becomes a bubble; load stall not counted.
5. MEM_TIMEOUT=4, i_mem_ready=0 for 6 cycles -> o_mem_timeout rises after the 4th frozen cycle and stays 1 after i_mem_ready returns, until i_rst.
6. Destination $0 load followed by a use of $0 -> no stall; o_EX_MEM_reg_write=0. Also assert i_rst mid-freeze -> all outputs at reset values asynchronously.
